// File: rtl/seq_shift_rotate_unit_if.sv
// Request/response bundle for the sequential shift/rotate unit.
// The master issues operations and consumes results; the slave is the unit itself.
interface seq_shift_rotate_unit_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       mode;
  logic [WIDTH-1:0] src;
  logic [SHW-1:0]   amount;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flag_c;
  logic             busy;

  modport master (
    output in_valid, mode, src, amount, out_ready,
    input  in_ready, out_valid, result, flag_n, flag_z, flag_c, busy
  );

  modport slave (
    input  in_valid, mode, src, amount, out_ready,
    output in_ready, out_valid, result, flag_n, flag_z, flag_c, busy
  );
endinterface

// File: rtl/seq_shift_rotate_unit.sv
// Multi-cycle LSL/LSR/ASR/ROR engine: shifts STEP bits per clock and
// presents the result with N/Z/C flags under a valid/ready handshake.
module seq_shift_rotate_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5,
  parameter int STEP  = 1
) (
  input  logic clk,
  input  logic rst_n,
  seq_shift_rotate_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHW-1:0]   STEP_K = SHW'(STEP);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  state_t           state;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   rem_q;
  logic [SHW-1:0]   k_step;
  logic [WIDTH:0]   step_res;
  logic [WIDTH-1:0] result_q;
  logic             flag_n_q, flag_z_q, flag_c_q;
  logic             out_valid_q, busy_q;

  // One step of k positions (k >= 1); returns {carry_out, shifted_value}.
  function automatic logic [WIDTH:0] shift_step(input logic [1:0]       m,
                                                input logic [WIDTH-1:0] v,
                                                input logic [SHW-1:0]   k);
    logic [WIDTH-1:0]        nxt;
    logic signed [WIDTH-1:0] sv;
    logic                    c;
    sv  = v;
    nxt = v;
    c   = 1'b0;
    case (m)
      2'b00: begin
        nxt = v << k;
        c   = |(v & (ONE << (WIDTH - int'(k))));
      end
      2'b01: begin
        nxt = v >> k;
        c   = |(v & (ONE << (k - 1'b1)));
      end
      2'b10: begin
        // MSB never changes under >>>, so the original sign keeps filling.
        nxt = $unsigned(sv >>> k);
        c   = |(v & (ONE << (k - 1'b1)));
      end
      default: begin
        nxt = (v >> k) | (v << (WIDTH - int'(k)));
        c   = nxt[WIDTH-1];
      end
    endcase
    return {c, nxt};
  endfunction

  always_comb begin
    k_step   = (rem_q < STEP_K) ? rem_q : STEP_K;
    step_res = shift_step(mode_q, work_q, k_step);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rem_q       <= '0;
      result_q    <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_c_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mode_q <= bus.mode;
            work_q <= bus.src;
            rem_q  <= bus.amount;
            busy_q <= 1'b1;
            if (bus.amount == '0) begin
              state       <= DONE;
              result_q    <= bus.src;
              flag_n_q    <= bus.src[WIDTH-1];
              flag_z_q    <= (bus.src == '0);
              flag_c_q    <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work_q <= step_res[WIDTH-1:0];
          rem_q  <= rem_q - k_step;
          // Last step: the carry of this step is the one the flags report.
          if (rem_q == k_step) begin
            state       <= DONE;
            result_q    <= step_res[WIDTH-1:0];
            flag_n_q    <= step_res[WIDTH-1];
            flag_z_q    <= (step_res[WIDTH-1:0] == '0);
            flag_c_q    <= step_res[WIDTH];
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_shift_rotate_unit.sv
// Randomised and directed bench for seq_shift_rotate_unit, with one STEP=1
// and one STEP=4 instance checked against an arithmetic reference model.
module tb_seq_shift_rotate_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int          sel = 1;
  logic        in_valid = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [31:0] src = '0;
  logic [4:0]  amount = '0;
  logic        out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  seq_shift_rotate_unit_if #(.WIDTH(32), .SHW(5)) b1 ();
  seq_shift_rotate_unit_if #(.WIDTH(32), .SHW(5)) b4 ();

  seq_shift_rotate_unit #(.WIDTH(32), .SHW(5), .STEP(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  seq_shift_rotate_unit #(.WIDTH(32), .SHW(5), .STEP(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  assign b1.in_valid  = (sel == 1) && in_valid;
  assign b4.in_valid  = (sel == 4) && in_valid;
  assign b1.out_ready = (sel == 1) && out_ready;
  assign b4.out_ready = (sel == 4) && out_ready;
  assign b1.mode = mode;   assign b4.mode = mode;
  assign b1.src = src;     assign b4.src = src;
  assign b1.amount = amount; assign b4.amount = amount;

  logic        o_valid, o_ready_in, o_busy, o_n, o_z, o_c;
  logic [31:0] o_result;
  assign o_valid    = (sel == 4) ? b4.out_valid : b1.out_valid;
  assign o_ready_in = (sel == 4) ? b4.in_ready  : b1.in_ready;
  assign o_busy     = (sel == 4) ? b4.busy      : b1.busy;
  assign o_result   = (sel == 4) ? b4.result    : b1.result;
  assign o_n        = (sel == 4) ? b4.flag_n    : b1.flag_n;
  assign o_z        = (sel == 4) ? b4.flag_z    : b1.flag_z;
  assign o_c        = (sel == 4) ? b4.flag_c    : b1.flag_c;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s (step=%0d) got=%0h expected=%0h", tag, sel, got, exp);
    end
  endtask

  // Reference: {carry, result} from whole-word arithmetic on widened operands.
  function automatic logic [32:0] ref_op(input logic [1:0] m, input logic [31:0] s, input int a);
    logic [32:0] t;
    logic [63:0] d;
    logic [31:0] r;
    logic        c;
    case (m)
      2'b00: begin t = {1'b0, s} << a; r = t[31:0]; c = t[32]; end
      2'b01: begin t = {s, 1'b0} >> a; r = t[32:1]; c = t[0]; end
      2'b10: begin t = $unsigned($signed({s, 1'b0}) >>> a); r = t[32:1]; c = t[0]; end
      default: begin d = {s, s} >> a; r = d[31:0]; c = (a == 0) ? 1'b0 : r[31]; end
    endcase
    return {c, r};
  endfunction

  task automatic run_op(input int st, input logic [1:0] m, input logic [31:0] s,
                        input logic [4:0] a, input int hold);
    logic [32:0] exp;
    int lat, cnt;
    exp = ref_op(m, s, int'(a));
    lat = (int'(a) + st - 1) / st;
    @(negedge clk);
    sel = st; in_valid = 1'b1; mode = m; src = s; amount = a; out_ready = 1'b0;
    #1;
    chk("in_ready_idle", o_ready_in, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cnt = 0;
    while (!o_valid && cnt < 100) begin
      chk("in_ready_busy", o_ready_in, 0);
      @(posedge clk); #1;
      cnt++;
    end
    chk("latency", cnt, lat);
    chk("out_valid", o_valid, 1);
    chk("result", o_result, exp[31:0]);
    chk("flag_n", o_n, exp[31]);
    chk("flag_z", o_z, exp[31:0] == 0);
    chk("flag_c", o_c, exp[32]);
    chk("busy_done", o_busy, 1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", o_valid, 1);
      chk("hold_result", o_result, exp[31:0]);
      chk("hold_flags", {o_n, o_z, o_c}, {exp[31], exp[31:0] == 0, exp[32]});
      chk("hold_in_ready", o_ready_in, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_valid", o_valid, 0);
    chk("idle_in_ready", o_ready_in, 1);
    chk("idle_busy", o_busy, 0);
    chk("idle_flags_kept", {o_n, o_z, o_c, o_result}, {exp[31], exp[31:0] == 0, exp[32], exp[31:0]});
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int k = 0; k < 2; k++) begin
      sel = (k == 0) ? 1 : 4;
      #1;
      chk(tag, {o_valid, o_busy, o_n, o_z, o_c, o_ready_in, o_result},
               {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    run_op(1, 2'b00, 32'hFFFF_FFFF, 5'd1, 0);
    run_op(1, 2'b01, 32'hFFFF_FFFF, 5'd31, 0);
    run_op(1, 2'b01, 32'hFFFF_FFFF, 5'd0, 0);
    run_op(1, 2'b11, 32'hFFFF_0000, 5'd1, 0);
    run_op(1, 2'b11, 32'h0000_FFFF, 5'd1, 0);
    run_op(1, 2'b10, 32'h8000_0000, 5'd4, 0);
    run_op(1, 2'b01, 32'h0000_0001, 5'd1, 0);
    run_op(1, 2'b00, 32'h1234_5678, 5'd8, 5);
    run_op(4, 2'b00, 32'h0000_0001, 5'd7, 0);
    run_op(4, 2'b10, 32'h8765_4321, 5'd31, 2);
    run_op(4, 2'b11, 32'hDEAD_BEEF, 5'd0, 1);

    // Abort a STEP=4 operation mid-shift.
    @(negedge clk);
    sel = 4; in_valid = 1'b1; mode = 2'b00; src = 32'hFFFF_FFFF; amount = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("abort_in_shift", o_busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sel = 4;
    #1;
    chk("abort_no_valid", o_valid, 0);

    for (int i = 0; i < 60; i++) begin
      logic [4:0] a;
      a = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(0, 1) * 31) : 5'($urandom_range(0, 31));
      run_op((i % 2 == 0) ? 1 : 4, 2'($urandom_range(0, 3)), $urandom, a, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
